fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch front end that replaces the single-register IF stage with a pipelined request/response fetcher and a DEPTH-entry prefetch queue.
- Issues in-order word requests to instruction memory and tracks outstanding responses.
- Buffers returned instructions with their PC+4 and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding stale in-flight responses.

---
 rtl/fetch_queue_unit.sv | 86 ++++++++
 tb/tb_fetch_queue_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: pipelined instruction fetcher with a DEPTH-entry prefetch queue and redirect flush; define FETCH_BYPASS_EN to forward responses straight to decode when the queue is empty
module fetch_queue_unit #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int ADDR_SHIFT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [XLEN-1:0]           imem_req_addr,
  input  logic                      imem_resp_valid,
  input  logic [XLEN-1:0]           imem_resp_data,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           redirect_pc,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [XLEN-1:0]           inst_data,
  output logic [XLEN-1:0]           inst_pc4,
  output logic [$clog2(DEPTH):0]    inflight
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] FULL = (CW+1)'(DEPTH);
  logic [XLEN-1:0] pc, resp_pc;
  logic [CW-1:0] cnt, drop_cnt;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [XLEN-1:0] q_data [DEPTH];
  logic [XLEN-1:0] q_pc4 [DEPTH];
  logic [CW:0] used;
  logic empty, rv, keep, byp, fire, push, pop;
  always_comb begin
    used = {1'b0, cnt} + {1'b0, inflight};
    empty = cnt == '0;
    rv = imem_resp_valid && !rst;
    keep = rv && drop_cnt == '0 && !redirect_valid;
`ifdef FETCH_BYPASS_EN
    byp = keep && empty;
`else
    byp = 1'b0;
`endif
    imem_req_valid = !rst && !redirect_valid && used < FULL;
    fire = imem_req_valid && imem_req_ready;
    inst_valid = (!empty || byp) && !redirect_valid;
    pop = inst_valid && inst_ready && !empty;
    push = keep && !(byp && inst_ready);
    inst_data = !empty ? q_data[rd_ptr] : byp ? imem_resp_data : '0;
    inst_pc4 = !empty ? q_pc4[rd_ptr] : byp ? resp_pc + XLEN'(4) : '0;
  end
  assign imem_req_addr = pc >> ADDR_SHIFT;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      resp_pc <= RESET_PC;
      cnt <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      inflight <= inflight + CW'(fire) - CW'(rv);
      if (redirect_valid) begin
        pc <= redirect_pc;
        resp_pc <= redirect_pc;
        cnt <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        drop_cnt <= inflight - CW'(rv);
      end else begin
        if (fire) pc <= pc + XLEN'(4);
        if (keep) resp_pc <= resp_pc + XLEN'(4);
        if (rv && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= imem_resp_data;
      q_pc4[wr_ptr] <= resp_pc + XLEN'(4);
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed checks of streaming, backpressure, redirect, pc wrap, reset and bypass
module tb_fetch_queue_unit;
  logic clk = 0, rst = 1;
  logic imem_req_valid, imem_req_ready = 0;
  logic [31:0] imem_req_addr;
  logic imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic inst_valid, inst_ready = 0;
  logic [31:0] inst_data, inst_pc4;
  logic [2:0] inflight;
  logic auto_mem = 1, mem_valid = 0, man_valid = 0;
  logic [31:0] mem_data = 0, man_data = 0;
  int lat = 1, cyc = 0, checks = 0, errors = 0, nfire = 0, ndeliv = 0;
  logic [31:0] exp_req = 0, exp_pc = 0;
  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t pend[$];
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  assign imem_resp_valid = auto_mem ? mem_valid : man_valid;
  assign imem_resp_data = auto_mem ? mem_data : man_data;
  fetch_queue_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc4(inst_pc4),
    .inflight(inflight)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (rst || !auto_mem) begin
      pend.delete();
      mem_valid = 0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_valid = 1;
      mem_data = pend[0].addr << 2;
      pend.delete(0);
    end else mem_valid = 0;
    @(negedge clk);
    if (auto_mem && !rst && imem_req_valid && imem_req_ready) pend.push_back('{imem_req_addr, cyc + lat});
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic mon(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_req >> 2);
        exp_req += 4;
        nfire++;
      end
      if (inst_valid && inst_ready) begin
        chk("inst_data", inst_data, exp_pc);
        chk("inst_pc4", inst_pc4, exp_pc + 4);
        exp_pc += 4;
        ndeliv++;
      end
      step();
    end
  endtask
  task automatic do_reset();
    rst = 1;
    redirect_valid = 0;
    man_valid = 0;
    step();
    @(negedge clk);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc4", inst_pc4, 0);
    step();
    rst = 0;
    exp_req = 0;
    exp_pc = 0;
    nfire = 0;
    ndeliv = 0;
  endtask
  initial begin
    imem_req_ready = 1;
    inst_ready = 1;
    lat = 1;
    do_reset();
    mon(12);
    chk("stream_fires", nfire, 12);
    chk("stream_deliv", ndeliv, 10);
    inst_ready = 0;
    do_reset();
    mon(20);
    chk("bp_fires", nfire, 4);
    chk("bp_deliv", ndeliv, 0);
    chk("bp_inflight", 32'(inflight), 0);
    chk("bp_req_valid", 32'(imem_req_valid), 0);
    chk("bp_inst_valid", 32'(inst_valid), 1);
    chk("bp_head", inst_data, 0);
    inst_ready = 1;
    mon(16);
    chk("bp_fires2", nfire, 19);
    chk("bp_deliv2", ndeliv, 16);
    lat = 3;
    do_reset();
    step();
    step();
    step();
    redirect_valid = 1;
    redirect_pc = 32'h100;
    @(negedge clk);
    chk("redir_inflight", 32'(inflight), 3);
    chk("redir_req_valid", 32'(imem_req_valid), 0);
    chk("redir_inst_valid", 32'(inst_valid), 0);
    step();
    redirect_valid = 0;
    exp_req = 32'h100;
    exp_pc = 32'h100;
    ndeliv = 0;
    mon(15);
    chk("redir_deliv", 32'(ndeliv >= 5), 1);
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("wrap_inst_valid", 32'(inst_valid), 0);
    step();
    redirect_valid = 0;
    exp_req = 32'hFFFF_FFFC;
    exp_pc = 32'hFFFF_FFFC;
    ndeliv = 0;
    mon(15);
    chk("wrap_deliv", 32'(ndeliv >= 3), 1);
    inst_ready = 0;
    do_reset();
    step();
    step();
    step();
    step();
    step();
    @(negedge clk);
    chk("mid_inflight", 32'(inflight), 2);
    chk("mid_inst_valid", 32'(inst_valid), 1);
    chk("mid_head", inst_data, 0);
    chk("mid_head_pc4", inst_pc4, 4);
    #1;
    do_reset();
    auto_mem = 0;
    imem_req_ready = 1;
    inst_ready = 0;
    do_reset();
    step();
    step();
    step();
    imem_req_ready = 0;
    man_valid = 1;
    man_data = 32'h1111;
    @(negedge clk);
    chk("sr_inflight3", 32'(inflight), 3);
    step();
    man_data = 32'hDEAD;
    redirect_valid = 1;
    redirect_pc = 32'h200;
    inst_ready = 1;
    @(negedge clk);
    chk("sr_inst_valid", 32'(inst_valid), 0);
    chk("sr_req_valid", 32'(imem_req_valid), 0);
    chk("sr_inflight2", 32'(inflight), 2);
    step();
    redirect_valid = 0;
    man_valid = 0;
    inst_ready = 0;
    @(negedge clk);
    chk("sr_empty", 32'(inst_valid), 0);
    chk("sr_inflight1", 32'(inflight), 1);
    chk("sr_req_valid2", 32'(imem_req_valid), 1);
    chk("sr_req_addr", imem_req_addr, 32'h80);
    step();
    man_valid = 1;
    man_data = 32'hBAD;
    @(negedge clk);
    chk("sr_addr_stable", imem_req_addr, 32'h80);
    chk("sr_inflight1b", 32'(inflight), 1);
    step();
    man_valid = 0;
    imem_req_ready = 1;
    @(negedge clk);
    chk("sr_stale_drop", 32'(inst_valid), 0);
    chk("sr_inflight0", 32'(inflight), 0);
    chk("sr_req_valid3", 32'(imem_req_valid), 1);
    step();
    imem_req_ready = 0;
    man_valid = 1;
    man_data = 32'h200;
    @(negedge clk);
    chk("sr_inflight_new", 32'(inflight), 1);
    chk("sr_resp_cycle_valid", 32'(inst_valid), 32'(BYP));
    step();
    man_valid = 0;
    inst_ready = 1;
    @(negedge clk);
    chk("sr_new_valid", 32'(inst_valid), 1);
    chk("sr_new_data", inst_data, 32'h200);
    chk("sr_new_pc4", inst_pc4, 32'h204);
    chk("sr_next_addr", imem_req_addr, 32'h81);
    step();
    inst_ready = 0;
    @(negedge clk);
    chk("sr_popped", 32'(inst_valid), 0);
    imem_req_ready = 0;
    inst_ready = 1;
    do_reset();
    redirect_valid = 1;
    redirect_pc = 32'h20;
    step();
    redirect_valid = 0;
    imem_req_ready = 1;
    @(negedge clk);
    chk("byp_req_valid", 32'(imem_req_valid), 1);
    chk("byp_req_addr", imem_req_addr, 32'h8);
    step();
    imem_req_ready = 0;
    man_valid = 1;
    man_data = 32'h20;
    @(negedge clk);
    chk("byp_same_valid", 32'(inst_valid), 32'(BYP));
    chk("byp_same_pc4", inst_pc4, BYP ? 32'h24 : 32'h0);
    chk("byp_same_data", inst_data, BYP ? 32'h20 : 32'h0);
    step();
    man_valid = 0;
    @(negedge clk);
    chk("byp_next_valid", 32'(inst_valid), 32'(!BYP));
    chk("byp_next_pc4", inst_pc4, BYP ? 32'h0 : 32'h24);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
